code_serializer: RTL and testbench
==================================

CODE_SERIALIZER -- requirements
Module: code_serializer

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, meaning code bits per transmission (legal range 1..16).
REQ-002 SHALL have parameter GAP, default 2, meaning idle cycles with ser_val=0 between consecutive code bits (legal range 0..255).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port code_valid  input  1  a code is offered on code_data.
REQ-006 SHALL have port code_data  input  CODE_LEN  the code to send, MSB sent first.
REQ-007 SHALL have port code_ready  output  1  block is ready to accept a code.
REQ-008 SHALL have port ser_val  output  1  serial bit strobe to the lock checker.
REQ-009 SHALL have port ser_data  output  1  serial bit value, meaningful only while ser_val=1.
REQ-010 SHALL have port chk_val  input  1  checker response valid.
REQ-011 SHALL have port chk_data  input  1  checker response: 1 means unlocked.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking the end of a transaction.
REQ-013 SHALL have port unlocked  output  1  result of the last transaction.
REQ-014 SHALL have port error  output  1  last transaction got no valid checker response.

Function
REQ-015 SHALL implement the states IDLE, SEND, GAP_WAIT, RESP, FLUSH and DONE.
REQ-016 SHALL drive code_ready=1 only in IDLE; a code is accepted on a cycle where code_valid=1 and code_ready=1, and code_data is latched into a shift register.
REQ-017 SHALL ignore code_valid outside IDLE, with no effect on the transaction in progress.
REQ-018 SHALL be in SEND on the cycle after accept; SEND drives ser_val=1 with ser_data equal to the current MSB for exactly one cycle.
REQ-019 SHALL go from SEND to GAP_WAIT for GAP cycles with ser_val=0, ser_data=0, then return to SEND for the next bit; when GAP=0, SEND is followed directly by SEND.
REQ-020 SHALL, with accept at cycle 0, send bit k (k=0 is the MSB) at cycle 1+k*(GAP+1).
REQ-021 SHALL go from the last bit's SEND directly to RESP, with no trailing gap.
REQ-022 SHALL, in RESP (one cycle), sample chk_val and chk_data: unlocked := chk_val & chk_data, error := ~chk_val.
REQ-023 SHALL, in FLUSH (one cycle), drive ser_val=1, ser_data=0 so that the checker returns to its idle state.
REQ-024 SHALL, in DONE, pulse done=1 for one cycle and then return to IDLE with code_ready=1 on the following cycle.
REQ-025 SHALL hold unlocked and error stable from RESP until the next accept, and clear both on accept.
REQ-026 SHALL, after the final bit L, place RESP at L+1, FLUSH at L+2, DONE at L+3, and make the next accept possible at L+4.
REQ-027 SHALL drive ser_val, ser_data, code_ready and done from registered state only, with no combinational path from any input.

Reset
REQ-028 SHALL, while rstn=0, force state IDLE and clear the shift register and counters.
REQ-029 SHALL hold reset outputs: code_ready=1, ser_val=0, ser_data=0, done=0, unlocked=0, error=0.
REQ-030 SHALL, on reset mid-transaction, drop ser_val asynchronously and discard the transaction with no done pulse.

Configuration
REQ-031 SHALL, with macro CODE_SER_RESP_EN defined, include the RESP state and the unlocked/error logic as above.
REQ-032 SHALL, without CODE_SER_RESP_EN, skip RESP: the last SEND goes to FLUSH at L+1 and DONE at L+2; unlocked and error are tied to 0; chk_val and chk_data are unused.

Structure
REQ-033 SHALL place the state enum typedef, CODE_LEN_MAX=16 and the GAP counter width in shared package safe_lock_pkg.
REQ-034 SHALL implement bit spacing in one sub-module, ser_gap_timer, a loadable down-counter that signals expiry.

Verification
REQ-035 SHALL cover: CODE_LEN=4, GAP=2, code 4'b1011 accepted at cycle 0, checker responds chk_val=1, chk_data=1 -> ser_val high at cycles 1, 4, 7, 10 with data 1, 0, 1, 1; RESP at 11; FLUSH at 12 (ser_val=1, data 0); done at 13; unlocked=1, error=0.
REQ-036 SHALL cover: code 4'b1001 with checker chk_val=1, chk_data=0 -> done at 13; unlocked=0, error=0.
REQ-037 SHALL cover: GAP=0, code 4'b1011 -> ser_val high on four consecutive cycles 1..4; RESP at 5; FLUSH at 6; done at 7.
REQ-038 SHALL cover: chk_val held 0 -> error=1, unlocked=0; code_valid pulsed at cycle 5 -> ignored, with code_ready=0 throughout.
REQ-039 SHALL cover: rstn low at cycle 6 -> ser_val=0 immediately, no done pulse; after rstn release, code_ready=1 and a new code is accepted normally.
REQ-040 SHALL cover: build without CODE_SER_RESP_EN, code 4'b1011, GAP=2 -> FLUSH at 11, done at 12; unlocked=0 and error=0 always.

Source files
------------

// File: rtl/safe_lock_pkg.sv
// Shared types and sizing for the code serializer and its gap timer.
package safe_lock_pkg;

  localparam int CODE_LEN_MAX = 16;
  localparam int GAP_W        = 8;
  localparam int BIT_CNT_W    = $clog2(CODE_LEN_MAX);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    GAP_WAIT,
    RESP,
    FLUSH,
    DONE
  } ser_state_e;

endpackage

// File: rtl/ser_gap_timer.sv
// Loadable down-counter timing the idle gap between serial code bits.
module ser_gap_timer
  import safe_lock_pkg::*;
#(
  parameter int W = GAP_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/code_serializer.sv
// Serializes a code MSB-first with GAP idle cycles between bits, then flushes the checker.
// Define CODE_SER_RESP_EN to sample the checker response (RESP state, unlocked/error).
//
// state    | meaning
// IDLE     | code_ready=1, waiting for code_valid
// SEND     | ser_val=1, current MSB on ser_data
// GAP_WAIT | GAP idle cycles between bits
// RESP     | sample chk_val/chk_data
// FLUSH    | ser_val=1, ser_data=0 to return checker to idle
// DONE     | one-cycle done pulse
module code_serializer
  import safe_lock_pkg::*;
#(
  parameter int CODE_LEN = 4,
  parameter int GAP      = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                code_valid,
  input  logic [CODE_LEN-1:0] code_data,
  output logic                code_ready,
  output logic                ser_val,
  output logic                ser_data,
  input  logic                chk_val,
  input  logic                chk_data,
  output logic                done,
  output logic                unlocked,
  output logic                error
);

  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  ser_state_e            state_q;
  logic [CODE_LEN-1:0]   shift_q;
  logic [CODE_LEN-1:0]   shift_nx;
  logic [BIT_CNT_W-1:0]  bits_left_q;
  logic                  code_ready_q;
  logic                  ser_val_q;
  logic                  ser_data_q;
  logic                  done_q;
  logic                  gap_expired;

  assign shift_nx = shift_q << 1;

  // Reloaded on every SEND so the count always starts fresh for the gap that follows.
  ser_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (state_q == SEND),
    .load_val_i (GAP_LOAD),
    .expired_o  (gap_expired)
  );

`ifdef CODE_SER_RESP_EN
  logic unlocked_q;
  logic error_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
    end else if (state_q == IDLE && code_valid && code_ready_q) begin
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
    end else if (state_q == RESP) begin
      unlocked_q <= chk_val & chk_data;
      error_q    <= ~chk_val;
    end
  end

  assign unlocked = unlocked_q;
  assign error    = error_q;
`else
  logic unused_chk;
  assign unused_chk = chk_val ^ chk_data;
  assign unlocked   = 1'b0;
  assign error      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bits_left_q  <= '0;
      code_ready_q <= 1'b1;
      ser_val_q    <= 1'b0;
      ser_data_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      ser_val_q  <= 1'b0;
      ser_data_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (code_valid && code_ready_q) begin
            shift_q      <= code_data;
            bits_left_q  <= BIT_CNT_W'(CODE_LEN - 1);
            code_ready_q <= 1'b0;
            ser_val_q    <= 1'b1;
            ser_data_q   <= code_data[CODE_LEN-1];
            state_q      <= SEND;
          end
        end
        SEND: begin
          shift_q <= shift_nx;
          if (bits_left_q == '0) begin
`ifdef CODE_SER_RESP_EN
            state_q   <= RESP;
`else
            ser_val_q <= 1'b1;
            state_q   <= FLUSH;
`endif
          end else begin
            bits_left_q <= bits_left_q - 1'b1;
            if (GAP == 0) begin
              ser_val_q  <= 1'b1;
              ser_data_q <= shift_nx[CODE_LEN-1];
              state_q    <= SEND;
            end else begin
              state_q <= GAP_WAIT;
            end
          end
        end
        GAP_WAIT: begin
          if (gap_expired) begin
            ser_val_q  <= 1'b1;
            ser_data_q <= shift_q[CODE_LEN-1];
            state_q    <= SEND;
          end
        end
        RESP: begin
          ser_val_q <= 1'b1;
          state_q   <= FLUSH;
        end
        FLUSH: begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          code_ready_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign code_ready = code_ready_q;
  assign ser_val    = ser_val_q;
  assign ser_data   = ser_data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_code_serializer.sv
// Scoreboard bench for code_serializer: GAP=2 and GAP=0 instances, either response build.
module tb_code_serializer;

`ifdef CODE_SER_RESP_EN
  localparam bit RESP_EN = 1'b1;
`else
  localparam bit RESP_EN = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  int         cyc  = 0;
  logic [1:0] code_valid = '0;
  logic [1:0] chk_val    = '0;
  logic [1:0] chk_data   = '0;
  logic [3:0] code_data [2];
  logic [1:0] code_ready, ser_val, ser_data, done, unlocked, error;

  int checks = 0;
  int errors = 0;

  typedef struct {int d; int cyc; logic data;} ser_exp_t;
  typedef struct {int d; int cyc;} done_exp_t;
  ser_exp_t  ser_q  [$];
  done_exp_t done_q [$];
  bit [1:0]  done_seen = '0;
  ser_exp_t  me;
  done_exp_t md;

  code_serializer #(.CODE_LEN(4), .GAP(2)) u_gap2 (
    .clk(clk), .rstn(rstn), .code_valid(code_valid[0]), .code_data(code_data[0]),
    .code_ready(code_ready[0]), .ser_val(ser_val[0]), .ser_data(ser_data[0]),
    .chk_val(chk_val[0]), .chk_data(chk_data[0]), .done(done[0]),
    .unlocked(unlocked[0]), .error(error[0])
  );

  code_serializer #(.CODE_LEN(4), .GAP(0)) u_gap0 (
    .clk(clk), .rstn(rstn), .code_valid(code_valid[1]), .code_data(code_data[1]),
    .code_ready(code_ready[1]), .ser_val(ser_val[1]), .ser_data(ser_data[1]),
    .chk_val(chk_val[1]), .chk_data(chk_data[1]), .done(done[1]),
    .unlocked(unlocked[1]), .error(error[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      for (int d = 0; d < 2; d++) begin
        if (ser_val[d] === 1'b1) begin
          if (ser_q.size() == 0) begin
            check("ser_unexpected", ser_val[d], 0);
          end else begin
            me = ser_q.pop_front();
            check("ser_dut", d, me.d);
            check("ser_cycle", cyc, me.cyc);
            check("ser_data", ser_data[d], me.data);
          end
        end else begin
          check("ser_data_idle", ser_data[d], 0);
        end
        if (done[d] === 1'b1) begin
          done_seen[d] = 1'b1;
          if (done_q.size() == 0) begin
            check("done_unexpected", done[d], 0);
          end else begin
            md = done_q.pop_front();
            check("done_dut", d, md.d);
            check("done_cycle", cyc, md.cyc);
          end
        end
      end
    end
  end

  // Accept happens at the end of cycle t0; bit k goes out at t0+1+k*(gap+1).
  task automatic push_exp(input int d, input logic [3:0] code, input int gap, input int t0);
    int last;
    for (int k = 0; k < 4; k++) ser_q.push_back('{d, t0 + 1 + k * (gap + 1), code[3-k]});
    last = t0 + 1 + 3 * (gap + 1);
    ser_q.push_back('{d, last + (RESP_EN ? 2 : 1), 1'b0});
    done_q.push_back('{d, last + (RESP_EN ? 3 : 2)});
  endtask

  task automatic run_txn(input int d, input logic [3:0] code, input int gap,
                         input logic cv, input logic cd, input int pulse_rel);
    int t0;
    @(posedge clk); #1;
    chk_val[d]   = cv;
    chk_data[d]  = cd;
    done_seen[d] = 1'b0;
    check("ready_idle", code_ready[d], 1);
    code_valid[d] = 1'b1;
    code_data[d]  = code;
    t0 = cyc;
    push_exp(d, code, gap, t0);
    @(posedge clk); #1;
    code_valid[d] = 1'b0;
    check("ready_busy", code_ready[d], 0);
    check("unlocked_clr", unlocked[d], 0);
    check("error_clr", error[d], 0);
    while (!done_seen[d] && cyc < t0 + 60) begin
      if (cyc == t0 + pulse_rel) begin
        check("ready_during_pulse", code_ready[d], 0);
        code_valid[d] = 1'b1;
        code_data[d]  = 4'b0110;
      end else begin
        code_valid[d] = 1'b0;
      end
      @(posedge clk); #1;
    end
    code_valid[d] = 1'b0;
    check("done_seen", done_seen[d], 1);
    check("ready_after_done", code_ready[d], 1);
    check("ser_q_drained", ser_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    check("unlocked", unlocked[d], RESP_EN ? 32'(cv & cd) : 0);
    check("error", error[d], RESP_EN ? 32'(~cv) : 0);
  endtask

  task automatic run_reset(input logic [3:0] code);
    int t0;
    @(posedge clk); #1;
    chk_val[0]   = 1'b1;
    chk_data[0]  = 1'b1;
    done_seen[0] = 1'b0;
    code_valid[0] = 1'b1;
    code_data[0]  = code;
    t0 = cyc;
    push_exp(0, code, 2, t0);
    @(posedge clk); #1;
    code_valid[0] = 1'b0;
    while (cyc < t0 + 6) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    #1;
    check("rst_ser_val", ser_val[0], 0);
    check("rst_ready", code_ready[0], 1);
    ser_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    check("rst_ser_val_hold", ser_val[0], 0);
    check("rst_done_hold", done[0], 0);
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rst_no_done", done_seen[0], 0);
    check("rst_ready_after", code_ready[0], 1);
    check("rst_unlocked", unlocked[0], 0);
  endtask

  initial begin
    code_data[0] = '0;
    code_data[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", code_ready[d], 1);
      check("reset_ser_val", ser_val[d], 0);
      check("reset_ser_data", ser_data[d], 0);
      check("reset_done", done[d], 0);
      check("reset_unlocked", unlocked[d], 0);
      check("reset_error", error[d], 0);
    end
    rstn = 1'b1;

    run_txn(0, 4'b1011, 2, 1'b1, 1'b1, -1);
    run_txn(0, 4'b1001, 2, 1'b1, 1'b0, -1);
    run_txn(1, 4'b1011, 0, 1'b1, 1'b1, -1);
    run_txn(0, 4'b1101, 2, 1'b0, 1'b1, 5);
    run_reset(4'b1011);
    run_txn(0, 4'b0111, 2, 1'b1, 1'b1, -1);
    for (int i = 0; i < 4; i++) begin
      run_txn(i % 2, 4'($urandom_range(0, 15)), (i % 2 == 0) ? 2 : 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    run_txn(1, 4'b0000, 0, 1'b0, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
